// File: rtl/rt_icache_pkg.sv
// Shared types and constants for the RT-Core instruction cache.
package rt_icache_pkg;

   localparam int unsigned LINES_DFLT     = 32;
   localparam int unsigned WORDS_DFLT     = 4;
   localparam int unsigned ADDR_W_DFLT    = 16;
   localparam int unsigned INDEX_W_DFLT   = $clog2(LINES_DFLT);
   localparam int unsigned OFFS_W_DFLT    = $clog2(WORDS_DFLT);
   localparam int unsigned TAG_W_DFLT     = ADDR_W_DFLT - INDEX_W_DFLT - OFFS_W_DFLT;

   // Instruction word returned whenever there is no hit.
   localparam logic [15:0] RT_NOP = 16'hF000;

   typedef enum logic [1:0] {
      StIdle,
      StRefill,
      StInval
   } state_e;

endpackage

// File: rtl/rt_icache_store.sv
// Valid/tag/data flop arrays with a combinational read port.
module rt_icache_store
   import rt_icache_pkg::*;
#(
   parameter int unsigned LINES          = LINES_DFLT,
   parameter int unsigned WORDS_PER_LINE = WORDS_DFLT,
   parameter int unsigned TAG_W          = TAG_W_DFLT,
   parameter int unsigned INDEX_W        = $clog2(LINES),
   parameter int unsigned OFFS_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [OFFS_W-1:0]  rd_offs,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [15:0]        rd_word,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [OFFS_W-1:0]  wr_offs,
   input  logic [15:0]        wr_word,
   input  logic               set_en,
   input  logic [INDEX_W-1:0] set_index,
   input  logic [TAG_W-1:0]   set_tag,
   input  logic               inv_all
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [15:0]      data_q [LINES][WORDS_PER_LINE];

   // Valid bits: the only reset state; global clear wins over a set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (inv_all) begin
         valid_q <= '0;
      end else if (set_en) begin
         valid_q[set_index] <= 1'b1;
      end
   end

   // Tag and data storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (set_en) begin
         tag_q[set_index] <= set_tag;
      end
      if (wr_en) begin
         data_q[wr_index][wr_offs] <= wr_word;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_word  = data_q[rd_index][rd_offs];

endmodule

// File: rtl/rt_icache.sv
// Direct-mapped instruction cache serving the RT-Core fetch port, refilling from program ROM.
module rt_icache
   import rt_icache_pkg::*;
#(
   parameter int unsigned LINES          = LINES_DFLT,
   parameter int unsigned WORDS_PER_LINE = WORDS_DFLT,
   parameter int unsigned ADDR_W         = ADDR_W_DFLT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_req,
   input  logic [ADDR_W-1:0] icache_addr,
   output logic [15:0]       icache_data,
   output logic              icache_ready,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_rdata,
   input  logic              rom_valid,
   input  logic              inv_req,
   output logic              inv_busy,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int unsigned INDEX_W = $clog2(LINES);
   localparam int unsigned OFFS_W  = $clog2(WORDS_PER_LINE);
   localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFS_W;

   localparam logic [OFFS_W-1:0] LAST_WORD = OFFS_W'(WORDS_PER_LINE - 1);

   state_e               state_q, state_d;
   logic [TAG_W-1:0]     refill_tag_q, refill_tag_d;
   logic [INDEX_W-1:0]   refill_idx_q, refill_idx_d;
   logic [OFFS_W-1:0]    cnt_q, cnt_d;
   logic                 inv_pend_q, inv_pend_d;
   logic [31:0]          hit_count_q, hit_count_d;
   logic [31:0]          miss_count_q, miss_count_d;

   logic [OFFS_W-1:0]    req_offs;
   logic [INDEX_W-1:0]   req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [15:0]          rd_word;
   logic                 hit;
   logic                 miss_start;
   logic                 wr_en;
   logic                 set_en;
   logic                 inv_all;

   assign req_offs = icache_addr[OFFS_W-1:0];
   assign req_idx  = icache_addr[OFFS_W +: INDEX_W];
   assign req_tag  = icache_addr[ADDR_W-1 -: TAG_W];

   rt_icache_store #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_W),
      .INDEX_W        (INDEX_W),
      .OFFS_W         (OFFS_W)
   ) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (req_idx),
      .rd_offs   (req_offs),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_word   (rd_word),
      .wr_en     (wr_en),
      .wr_index  (refill_idx_q),
      .wr_offs   (cnt_q),
      .wr_word   (rom_rdata),
      .set_en    (set_en),
      .set_index (refill_idx_q),
      .set_tag   (refill_tag_q),
      .inv_all   (inv_all)
   );

   assign hit          = icache_req && rd_valid && (rd_tag == req_tag) && (state_q == StIdle);
   assign icache_ready = hit;
   assign icache_data  = hit ? rd_word : RT_NOP;
   assign rom_req      = (state_q == StRefill);
   assign rom_addr     = {refill_tag_q, refill_idx_q, cnt_q};
   assign inv_busy     = inv_pend_q || (state_q == StInval);
   assign hit_count    = hit_count_q;
   assign miss_count   = miss_count_q;

   // Next-state: invalidate beats a miss; a refill always runs to its last word.
   always_comb begin
      state_d      = state_q;
      refill_tag_d = refill_tag_q;
      refill_idx_d = refill_idx_q;
      cnt_d        = cnt_q;
      inv_pend_d   = inv_pend_q || inv_req;
      miss_start   = 1'b0;
      wr_en        = 1'b0;
      set_en       = 1'b0;
      inv_all      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (inv_req || inv_pend_q) begin
               state_d = StInval;
            end else if (icache_req && !hit) begin
               refill_tag_d = req_tag;
               refill_idx_d = req_idx;
               cnt_d        = '0;
               miss_start   = 1'b1;
               state_d      = StRefill;
            end
         end
         StRefill: begin
            if (rom_valid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + OFFS_W'(1);
               if (cnt_q == LAST_WORD) begin
                  set_en = 1'b1;
                  // Straight to INVAL so a discarded line is never seen as a hit.
                  state_d = (inv_pend_q || inv_req) ? StInval : StIdle;
               end
            end
         end
         StInval: begin
            inv_all    = 1'b1;
            inv_pend_d = 1'b0;
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Saturating event counters.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
         hit_count_d = hit_count_q + 32'd1;
      end
      if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
         miss_count_d = miss_count_q + 32'd1;
      end
   end

   // Control and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         refill_tag_q <= '0;
         refill_idx_q <= '0;
         cnt_q        <= '0;
         inv_pend_q   <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         refill_tag_q <= refill_tag_d;
         refill_idx_q <= refill_idx_d;
         cnt_q        <= cnt_d;
         inv_pend_q   <= inv_pend_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

endmodule
